// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for MIPS DIV/DIVU, result {rem, quo}.
// Optional DIV_EARLY_EXIT_EN skips the iteration when |a| < |b| and b is non-zero.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               div_stall,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);
    localparam int CntW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
    stateT            state;
    logic [CntW-1:0]  counter;
    logic [WIDTH-1:0] rem, quo, absB;
    logic             quoNeg, remNeg;
    logic             aNeg, bNeg;
    logic [WIDTH-1:0] absAIn, absBIn, nextRem, nextQuo;
    logic [WIDTH:0]   shifted, trial;
    always_comb begin
        aNeg      = signed_div & a[WIDTH-1];
        bNeg      = signed_div & b[WIDTH-1];
        absAIn    = aNeg ? -a : a;
        absBIn    = bNeg ? -b : b;
        shifted   = {rem, quo[WIDTH-1]};
        trial     = shifted - {1'b0, absB};
        nextRem   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        nextQuo   = {quo[WIDTH-2:0], ~trial[WIDTH]};
        div_stall = ~annul & ((state == IDLE & start) | state == BUSY);
    end
`ifdef DIV_EARLY_EXIT_EN
    logic early;
    assign early = (absBIn != '0) && (absAIn < absBIn);
`endif
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            result  <= '0;
            ready   <= 1'b0;
            counter <= '0;
            rem     <= '0;
            quo     <= '0;
            absB    <= '0;
            quoNeg  <= 1'b0;
            remNeg  <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        quo     <= absAIn;
                        absB    <= absBIn;
                        rem     <= '0;
                        quoNeg  <= aNeg ^ bNeg;
                        remNeg  <= aNeg;
                        counter <= '0;
`ifdef DIV_EARLY_EXIT_EN
                        if (early) begin
                            state  <= DONE;
                            ready  <= 1'b1;
                            result <= {a, {WIDTH{1'b0}}};
                        end else begin
                            state <= BUSY;
                        end
`else
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem     <= nextRem;
                    quo     <= nextQuo;
                    counter <= counter + 1'b1;
                    // The last step loads the corrected result so it is valid alongside ready
                    if (counter == CntW'(WIDTH - 1)) begin
                        state  <= DONE;
                        ready  <= 1'b1;
                        result <= {remNeg ? -nextRem : nextRem, quoNeg ? -nextQuo : nextQuo};
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter against an arithmetic reference model.
module tb_div_iter;
    localparam int W = 32;
    logic           clk = 1'b0, resetn = 1'b0, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           div_stall, ready;
    logic [2*W-1:0] result;
    logic [2*W-1:0] expHeld = '0;
    int             passCnt = 0, totalCnt = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul), .div_stall(div_stall), .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] refDiv(input bit sd, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 0) return {x, (sd && x[31]) ? 32'd1 : 32'hFFFF_FFFF};
        sx = sd ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sd ? longint'($signed(y)) : longint'({32'b0, y});
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int refStalls(input bit sd, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_EARLY_EXIT_EN
        logic [31:0] mx, my;
        mx = (sd && x[31]) ? -x : x;
        my = (sd && y[31]) ? -y : y;
        if (my != 0 && mx < my) return 1;
`endif
        return W + 1;
    endfunction

    task automatic doDiv(input bit sd, input logic [31:0] x, input logic [31:0] y, input bit scramble,
                         output logic [63:0] res, output int stalls, output bit ok);
        @(negedge clk);
        start = 1'b1; signed_div = sd; a = x; b = y;
        stalls = 0; ok = 1'b0; res = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (ready) begin
                ok = 1'b1;
                res = result;
            end else begin
                if (div_stall) stalls++;
                @(negedge clk);
                if (scramble) begin a = $urandom; b = $urandom; end
            end
        end
        start = 1'b0;
    endtask

    task automatic runCase(input string name, input bit sd, input logic [31:0] x, input logic [31:0] y,
                           input bit scramble);
        logic [63:0] res, exp;
        int          st;
        bit          ok;
        exp = refDiv(sd, x, y);
        doDiv(sd, x, y, scramble, res, st, ok);
        totalCnt++;
        if (!ok) $display("FAIL %s ready: timed out, no ready within 100 cycles", name);
        else passCnt++;
        totalCnt++;
        if (res !== exp) $display("FAIL %s result: got %h want %h (sd=%0b a=%h b=%h)", name, res, exp, sd, x, y);
        else passCnt++;
        totalCnt++;
        if (st != refStalls(sd, x, y)) $display("FAIL %s stalls: got %0d want %0d", name, st, refStalls(sd, x, y));
        else passCnt++;
        expHeld = exp;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; annul = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        totalCnt++;
        if (result !== '0 || ready !== 1'b0 || div_stall !== 1'b0)
            $display("FAIL reset: got result=%h ready=%b stall=%b want 0/0/0", result, ready, div_stall);
        else passCnt++;
        resetn = 1'b1;
    endtask

    task automatic test_divu_basic();
        runCase("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        totalCnt++;
        if (expHeld !== {32'd2, 32'd14}) $display("FAIL divu_100_7 model: got %h want %h", expHeld, {32'd2, 32'd14});
        else passCnt++;
        @(negedge clk); #1;
        totalCnt++;
        if (ready !== 1'b0) $display("FAIL ready_pulse: got ready=%b want 0", ready);
        else passCnt++;
        totalCnt++;
        if (result !== {32'd2, 32'd14}) $display("FAIL result_hold: got %h want %h", result, {32'd2, 32'd14});
        else passCnt++;
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int          st;
        bit          ok;
        doDiv(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, res, st, ok);
        totalCnt++;
        if (!ok || res !== {32'hFFFF_FFFE, 32'hFFFF_FFF2})
            $display("FAIL div_m100_7: got %h ok=%b want %h", res, ok, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        else passCnt++;
        doDiv(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, res, st, ok);
        totalCnt++;
        if (!ok || res !== {32'd2, 32'hFFFF_FFF2})
            $display("FAIL div_100_m7: got %h ok=%b want %h", res, ok, {32'd2, 32'hFFFF_FFF2});
        else passCnt++;
        expHeld = {32'd2, 32'hFFFF_FFF2};
    endtask

    task automatic test_corners();
        logic [63:0] res;
        int          st;
        bit          ok;
        doDiv(1'b0, 32'd7, 32'd0, 1'b0, res, st, ok);
        totalCnt++;
        if (!ok || res !== {32'd7, 32'hFFFF_FFFF} || st != W + 1)
            $display("FAIL divu_by_zero: got %h stalls=%0d want %h stalls=%0d", res, st, {32'd7, 32'hFFFF_FFFF}, W + 1);
        else passCnt++;
        doDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, st, ok);
        totalCnt++;
        if (!ok || res !== {32'd0, 32'h8000_0000})
            $display("FAIL div_overflow: got %h want %h", res, {32'd0, 32'h8000_0000});
        else passCnt++;
        expHeld = {32'd0, 32'h8000_0000};
        runCase("divu_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
    endtask

    task automatic test_annul();
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        #1;
        totalCnt++;
        if (div_stall !== 1'b0) $display("FAIL annul_stall: got %b want 0", div_stall);
        else passCnt++;
        @(negedge clk);
        annul = 1'b0;
        #1;
        totalCnt++;
        if (div_stall !== 1'b0) $display("FAIL annul_idle: got stall=%b want 0", div_stall);
        else passCnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ready) seen = 1'b1;
        end
        totalCnt++;
        if (seen || result !== expHeld) $display("FAIL annul_no_ready: got ready_seen=%b result=%h want 0 %h", seen, result, expHeld);
        else passCnt++;
        @(negedge clk);
        start = 1'b1; annul = 1'b1;
        #1;
        totalCnt++;
        if (div_stall !== 1'b0) $display("FAIL annul_start_stall: got %b want 0", div_stall);
        else passCnt++;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        totalCnt++;
        if (div_stall !== 1'b0) $display("FAIL annul_start_idle: got stall=%b want 0", div_stall);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        int st = 0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd20; b = 32'd3;
        for (int i = 0; i < 100 && !found; i++) begin
            #1;
            if (ready) found = 1'b1;
            else @(negedge clk);
        end
        totalCnt++;
        if (!found || result !== {32'd2, 32'd6}) $display("FAIL b2b_first: got %h found=%b want %h", result, found, {32'd2, 32'd6});
        else passCnt++;
        @(negedge clk);
        a = 32'd9; b = 32'd2;
        #1;
        totalCnt++;
        if (div_stall !== 1'b1) $display("FAIL b2b_restart: got stall=%b want 1", div_stall);
        else passCnt++;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (i > 0) #1;
            if (ready) found = 1'b1;
            else begin
                if (div_stall) st++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        totalCnt++;
        if (!found || result !== {32'd1, 32'd4} || st != refStalls(1'b0, 32'd9, 32'd2))
            $display("FAIL b2b_second: got %h stalls=%0d want %h stalls=%0d", result, st, {32'd1, 32'd4}, refStalls(1'b0, 32'd9, 32'd2));
        else passCnt++;
        expHeld = {32'd1, 32'd4};
    endtask

    task automatic test_reset_mid_busy();
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        totalCnt++;
        if (ready !== 1'b0 || div_stall !== 1'b0 || result !== '0)
            $display("FAIL reset_mid_busy: got ready=%b stall=%b result=%h want 0/0/0", ready, div_stall, result);
        else passCnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ready) seen = 1'b1;
        end
        totalCnt++;
        if (seen) $display("FAIL reset_discard: got a ready pulse want none");
        else passCnt++;
        expHeld = '0;
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        bit          sd;
        for (int n = 0; n < 40; n++) begin
            sd = 1'($urandom % 2);
            x  = $urandom;
            case ($urandom % 4)
                0: y = $urandom;
                1: y = $urandom_range(1, 15);
                2: y = (n % 8 == 2) ? 32'd0 : $urandom_range(1, 1000);
                default: begin x = $urandom % 50; y = $urandom; end
            endcase
            runCase($sformatf("rand%0d", n), sd, x, y, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_corners();
        test_annul();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
